heart_beat_monitor: RTL and testbench

//  Receive-side checker for a heart_beat-style square wave (e.g. from a remote board or other clock domain).

---
 rtl/heart_beat_monitor.sv | 139 +++++++++++++
 tb/tb_heart_beat_monitor.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/heart_beat_monitor.sv
// Receive-side heartbeat checker: synchronises an asynchronous square wave, measures
// the interval between its edges, declares it alive after a run of in-tolerance intervals.
module heart_beat_monitor #(
  parameter int CLK_VALUE   = 100000000,
  parameter int SPEED_GRADE = 2,
  parameter int TOL_PCT     = 25,
  parameter int LOCK_EDGES  = 4,
  parameter int SYNC_STAGES = 2,
  localparam longint HALF_CYC = longint'(CLK_VALUE) / (2 * SPEED_GRADE),
  localparam longint MIN_CYC  = HALF_CYC * (100 - TOL_PCT) / 100,
  localparam longint MAX_CYC  = HALF_CYC * (100 + TOL_PCT) / 100,
  localparam int     CNT_W    = $clog2(MAX_CYC + 1)
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_heart_beat,
  input  logic             i_clr_err,
  output logic             o_alive,
  output logic             o_lock_lost,
  output logic [CNT_W-1:0] o_period_cyc,
  output logic [15:0]      o_err_cnt
);

  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_CYC);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CYC);

  typedef enum logic [1:0] {SEARCH, LOCKING, ALIVE} state_t;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   dly_p1;
  logic                   hb_edge;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W:0]         iv_raw;
  logic [CNT_W-1:0]       iv;
  logic                   in_range;
  logic                   timeout;
  logic                   lose;
  state_t                 state;
  logic [3:0]             good;

  function automatic logic [CNT_W-1:0] sat_cyc(input logic [CNT_W:0] v);
    return (v > {1'b0, MAX_V}) ? MAX_V : v[CNT_W-1:0];
  endfunction

  function automatic logic [15:0] sat_err(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage p0/p1: synchroniser chain followed by one delay flop for edge detection
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      sync_p0 <= '0;
      dly_p1  <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], i_heart_beat};
      dly_p1  <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign hb_edge = sync_p0[SYNC_STAGES-1] ^ dly_p1;

  // Range check uses the unsaturated interval: cnt parks at MAX_V, so an edge
  // arriving one cycle late still yields MAX+1 here and is rejected.
  assign iv_raw   = {1'b0, cnt} + (CNT_W+1)'(1);
  assign iv       = sat_cyc(iv_raw);
  assign in_range = (iv_raw >= {1'b0, MIN_V}) && (iv_raw <= {1'b0, MAX_V});
  assign timeout  = (cnt == MAX_V) && !hb_edge;
  assign lose     = (state == ALIVE) && ((hb_edge && !in_range) || timeout);

  // Stage p2: interval counter
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cnt <= '0;
    end else if (hb_edge) begin
      cnt <= '0;
    end else begin
      cnt <= iv;
    end
  end

  // Stage p3: lock FSM with registered status outputs
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state        <= SEARCH;
      good         <= '0;
      o_alive      <= 1'b0;
      o_lock_lost  <= 1'b0;
      o_period_cyc <= '0;
      o_err_cnt    <= '0;
    end else begin
      o_lock_lost <= 1'b0;
      case (state)
        SEARCH: begin
          if (hb_edge) begin
            state <= LOCKING;
            good  <= '0;
          end
        end
        LOCKING: begin
          if (hb_edge) begin
            if (!in_range) begin
              good <= '0;
            end else if (good == 4'(LOCK_EDGES - 1)) begin
              state   <= ALIVE;
              good    <= '0;
              o_alive <= 1'b1;
            end else begin
              good <= good + 4'd1;
            end
          end else if (timeout) begin
            state <= SEARCH;
            good  <= '0;
          end
        end
        ALIVE: begin
          if (lose) begin
            state       <= SEARCH;
            o_alive     <= 1'b0;
            o_lock_lost <= 1'b1;
          end
        end
        default: begin
          state   <= SEARCH;
          good    <= '0;
          o_alive <= 1'b0;
        end
      endcase

      if (hb_edge) o_period_cyc <= iv;

      if (i_clr_err) begin
        o_err_cnt <= '0;
      end else if (lose) begin
        o_err_cnt <= sat_err(o_err_cnt);
      end
    end
  end

endmodule

// File: tb/tb_heart_beat_monitor.sv
// Directed bench for heart_beat_monitor with HALF=50, MIN=40, MAX=60 cycles.
module tb_heart_beat_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hb = 1'b0;
  logic        clr = 1'b0;
  logic        alive;
  logic        lock_lost;
  logic [5:0]  period;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int lost_pulses = 0;

  heart_beat_monitor #(
    .CLK_VALUE(1000), .SPEED_GRADE(10), .TOL_PCT(20), .LOCK_EDGES(4), .SYNC_STAGES(2)
  ) dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_heart_beat(hb), .i_clr_err(clr),
    .o_alive(alive), .o_lock_lost(lock_lost), .o_period_cyc(period), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (lock_lost === 1'b1) lost_pulses++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic toggle();
    hb = ~hb;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // First edge plus four intervals of length iv; returns sampled 3 cycles after the last toggle.
  task automatic lock_train(input int iv, input string tag);
    toggle();
    repeat (4) begin
      tick(iv);
      toggle();
    end
    tick(2);
    check({tag, "_alive_pre"}, 32'(alive), 0);
    tick(1);
    check({tag, "_alive"}, 32'(alive), 1);
    check({tag, "_period"}, 32'(period), 32'(iv));
  endtask

  initial begin
    // 1: reset holds outputs low even with input activity
    tick(2);
    toggle(); tick(3); toggle(); tick(3);
    check("rst_alive", 32'(alive), 0);
    check("rst_lost", 32'(lock_lost), 0);
    check("rst_period", 32'(period), 0);
    check("rst_err", 32'(err_cnt), 0);
    hb = 1'b0;
    rst_n = 1'b1;
    tick(100);
    check("idle_alive", 32'(alive), 0);

    // 2: nominal square wave locks one cycle after the fifth edge
    lock_train(50, "nom");
    check("nom_no_lost", 32'(lost_pulses), 0);

    // 3: input stops -> timeout 61 cycles after the sample following the last edge
    tick(60);
    check("to_alive_hold", 32'(alive), 1);
    check("to_lost_pre", 32'(lock_lost), 0);
    tick(1);
    check("to_lost", 32'(lock_lost), 1);
    check("to_alive", 32'(alive), 0);
    check("to_err", 32'(err_cnt), 1);
    tick(1);
    check("to_lost_once", 32'(lock_lost), 0);
    check("to_period_hold", 32'(period), 50);

    // 4: boundary intervals MAX accepted, MAX+1 rejected, MIN accepted, MIN-1 rejected
    clr = 1'b1; tick(1); clr = 1'b0;
    check("clr_err", 32'(err_cnt), 0);
    lock_train(60, "max");
    tick(58); toggle();
    tick(2);
    check("max1_lost_pre", 32'(lock_lost), 0);
    tick(1);
    check("max1_lost", 32'(lock_lost), 1);
    check("max1_alive", 32'(alive), 0);
    check("max1_period_sat", 32'(period), 60);
    check("max1_err", 32'(err_cnt), 1);
    lock_train(40, "min");
    tick(36); toggle();
    tick(2);
    check("min1_lost_pre", 32'(lock_lost), 0);
    tick(1);
    check("min1_lost", 32'(lock_lost), 1);
    check("min1_period", 32'(period), 39);
    check("min1_err", 32'(err_cnt), 2);

    // 5: clear wins over a simultaneous increment; counter saturates
    lock_train(50, "clr");
    tick(27); toggle();
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_lost", 32'(lock_lost), 1);
    check("clr_err0", 32'(err_cnt), 0);
    force dut.o_err_cnt = 16'hFFFF;
    tick(1);
    release dut.o_err_cnt;
    lock_train(50, "sat");
    tick(60);
    check("sat_lost_pre", 32'(lock_lost), 0);
    tick(1);
    check("sat_lost", 32'(lock_lost), 1);
    check("sat_err", 32'(err_cnt), 32'hFFFF);

    // 6: reset mid-lock discards progress and clears the error count
    toggle();
    repeat (3) begin tick(50); toggle(); end
    tick(3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_alive", 32'(alive), 0);
    check("mid_rst_lost", 32'(lock_lost), 0);
    check("mid_rst_err", 32'(err_cnt), 0);
    check("mid_rst_period", 32'(period), 0);
    hb = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    toggle();
    repeat (3) begin tick(50); toggle(); end
    tick(3);
    check("relock_3_alive", 32'(alive), 0);
    tick(47); toggle();
    tick(2);
    check("relock_4_pre", 32'(alive), 0);
    tick(1);
    check("relock_4_alive", 32'(alive), 1);

    // Glitch: two edges one cycle apart while alive -> interval 1 rejected
    tick(47); toggle();
    tick(1); toggle();
    tick(2);
    check("glitch_lost_pre", 32'(lock_lost), 0);
    tick(1);
    check("glitch_lost", 32'(lock_lost), 1);
    check("glitch_period", 32'(period), 1);
    check("glitch_err", 32'(err_cnt), 1);
    tick(2);
    check("total_lost_pulses", 32'(lost_pulses), 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
